// File: rtl/core_ctrl.sv
// Layer sequencer for the weight-stationary convolution core: walks every kernel
// position through weight load, activation stream/execute and OFIFO drain into PSUM.
module core_ctrl #(
    parameter int unsigned ROW     = 8,
    parameter int unsigned COL     = 8,
    parameter int unsigned NUM_KIJ = 9,
    parameter int unsigned LEN_NIJ = 36,
    parameter int unsigned X_BASE  = 0,
    parameter int unsigned W_BASE  = 1024,
    parameter int unsigned P_BASE  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_idx
);
    localparam logic [33:0] IDLE_WORD = 34'h1800C0000;

    typedef enum logic [2:0] {
        S_IDLE, S_W_L0, S_W_LOAD, S_W_FLUSH, S_X_L0, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  kij_q, kij_d;
    logic [33:0] inst_q, inst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wr_d;

    // Next-state / counters. In DRAIN, cnt counts psum writes already issued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kij_d   = kij_q;
        wr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_W_L0;
                    cnt_d   = '0;
                    kij_d   = '0;
                end
            end
            S_W_L0: begin
                if (cnt_q == 16'(COL)) begin
                    state_d = S_W_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_W_LOAD: begin
                if (cnt_q == 16'(COL - 1)) begin
                    state_d = S_W_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_W_FLUSH: begin
                if (cnt_q == 16'(ROW - 1)) begin
                    state_d = S_X_L0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_X_L0: begin
                if (cnt_q == 16'(LEN_NIJ)) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EXEC: begin
                if (cnt_q == 16'(LEN_NIJ - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                // The cycle showing the last write is also the last DRAIN cycle.
                if (cnt_q == 16'(LEN_NIJ)) begin
                    cnt_d = '0;
                    if (kij_q == 4'(NUM_KIJ - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_W_L0;
                        kij_d   = kij_q + 4'd1;
                    end
                end else if (valid) begin
                    wr_d  = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                kij_d   = '0;
            end
        endcase
    end

    // Output word for the upcoming cycle, decoded from the next state so it is registered.
    logic [31:0] w_addr, x_addr, p_addr;
    always_comb begin
        w_addr = 32'(W_BASE) + 32'(kij_d) * 32'(COL) + 32'(cnt_d);
        x_addr = 32'(X_BASE) + 32'(cnt_d);
        p_addr = 32'(P_BASE) + 32'(cnt_q);
        inst_d = IDLE_WORD;
        case (state_d)
            S_W_L0: begin
                if (cnt_d < 16'(COL)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = w_addr[10:0];
                end
                if (cnt_d != 16'd0) inst_d[2] = 1'b1;
            end
            S_W_LOAD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_X_L0: begin
                if (cnt_d < 16'(LEN_NIJ)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = x_addr[10:0];
                end
                if (cnt_d != 16'd0) inst_d[2] = 1'b1;
            end
            S_EXEC: begin
                inst_d[3] = 1'b1;
                inst_d[1] = 1'b1;
            end
            S_DRAIN: begin
                if (wr_d) begin
                    inst_d[33]    = (kij_q != 4'd0);
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = p_addr[10:0];
                    inst_d[6]     = 1'b1;
                end
            end
            default: inst_d = IDLE_WORD;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kij_q   <= '0;
            inst_q  <= IDLE_WORD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kij_q   <= kij_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inst    = inst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign kij_idx = kij_q;
endmodule
